multicycle_control_unit: RTL and testbench

- Multicycle successor to the single-cycle RV32I main/ALU decoder.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port.
- Adds an optional memory-ready handshake, BNE support and an extended ALU-op decode.
- Sits between the instruction register/flags and the multicycle datapath muxes and enables.

---
 rtl/multicycle_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory port, plus the ALU-op decoder and immediate select.
module multicycle_control_unit #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit BNE_EN   = 1'b1,
  parameter bit EXT_ALU  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic       started_q, started_d;
  logic       ready, take;
  logic [1:0] aluop;
  logic       pc_en, ir_en, mw_en, rw_en, ill_en;

  assign ready     = MEM_WAIT ? mem_ready : 1'b1;
  assign take      = (BNE_EN && (funct3 == 3'b001)) ? ~zero : zero;
  assign started_d = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    adrsrc    = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    pc_en     = 1'b0;
    ir_en     = 1'b0;
    mw_en     = 1'b0;
    rw_en     = 1'b0;
    ill_en    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pc_en     = ready;
        ir_en     = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target is precomputed into ALUOut while the opcode is decoded
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1101111:             state_d = S_JAL;
          7'b1100011:             state_d = S_BRANCH;
          default: begin
            ill_en  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        rw_en     = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        mw_en  = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC <- target held in ALUOut while the ALU forms the link value OldPC+4
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pc_en   = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        pc_en   = take;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (!started_q) state_d = S_FETCH;
  end

  assign pcwrite  = started_q & pc_en;
  assign irwrite  = started_q & ir_en;
  assign memwrite = started_q & mw_en;
  assign regwrite = started_q & rw_en;
  assign illegal  = started_q & ill_en;
  assign state_o  = state_q;

  always_comb begin
    case (opcode)
      7'b0100011: immsrc = 2'b01;
      7'b1100011: immsrc = 2'b10;
      7'b1101111: immsrc = 2'b11;
      default:    immsrc = 2'b00;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000: alucontrol = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010: alucontrol = 3'b101;
          3'b110: alucontrol = 3'b011;
          3'b111: alucontrol = 3'b010;
          3'b100: alucontrol = EXT_ALU ? 3'b100 : 3'b000;
          3'b001: alucontrol = EXT_ALU ? 3'b110 : 3'b000;
          3'b101: alucontrol = EXT_ALU ? 3'b111 : 3'b000;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench: one vector per clock cycle for the default-parameter unit, with a
// second instance (BNE_EN=0, EXT_ALU=1) checked alongside; hand-written reset corner at the end.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;

  logic       pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  logic       pcwrite2, adrsrc2, irwrite2, memwrite2, regwrite2, illegal2;
  logic [1:0] resultsrc2, alusrca2, alusrcb2, immsrc2;
  logic [2:0] alucontrol2;
  logic [3:0] state_o2;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite), .resultsrc(resultsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state_o(state_o)
  );

  multicycle_control_unit #(.MEM_WAIT(1'b1), .BNE_EN(1'b0), .EXT_ALU(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite2), .adrsrc(adrsrc2),
    .irwrite(irwrite2), .memwrite(memwrite2), .regwrite(regwrite2), .resultsrc(resultsrc2),
    .alusrca(alusrca2), .alusrcb(alusrcb2), .immsrc(immsrc2), .alucontrol(alucontrol2),
    .illegal(illegal2), .state_o(state_o2)
  );

  // ctl = {pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal}
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [5:0] ctl;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       pc2;
    logic [2:0] alu2;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic f7, logic z, logic rdy,
                              logic [3:0] st, logic [5:0] ctl, logic [1:0] rs, logic [1:0] a,
                              logic [1:0] b, logic [1:0] imm, logic [2:0] alu, logic pc2,
                              logic [2:0] alu2);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl;
    v.rs = rs; v.a = a; v.b = b; v.imm = imm; v.alu = alu; v.pc2 = pc2; v.alu2 = alu2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset release + lw with three memory wait cycles
    vecs.push_back(mk(OP_LW,3'd0,0,0,1, 0,6'b000000,2'b10,2'b00,2'b10,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_LW,3'd0,0,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b00,3'b000,1,3'b000));
    vecs.push_back(mk(OP_LW,3'd0,0,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_LW,3'd0,0,0,1, 2,6'b000000,2'b00,2'b10,2'b01,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_LW,3'd0,0,0,0, 3,6'b010000,2'b00,2'b00,2'b00,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_LW,3'd0,0,0,0, 3,6'b010000,2'b00,2'b00,2'b00,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_LW,3'd0,0,0,0, 3,6'b010000,2'b00,2'b00,2'b00,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_LW,3'd0,0,0,1, 3,6'b010000,2'b00,2'b00,2'b00,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_LW,3'd0,0,0,0, 4,6'b000010,2'b01,2'b00,2'b00,2'b00,3'b000,0,3'b000));
    // sw with two memory wait cycles
    vecs.push_back(mk(OP_SW,3'd2,0,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b01,3'b000,1,3'b000));
    vecs.push_back(mk(OP_SW,3'd2,0,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b01,3'b000,0,3'b000));
    vecs.push_back(mk(OP_SW,3'd2,0,0,1, 2,6'b000000,2'b00,2'b10,2'b01,2'b01,3'b000,0,3'b000));
    vecs.push_back(mk(OP_SW,3'd2,0,0,0, 5,6'b010100,2'b00,2'b00,2'b00,2'b01,3'b000,0,3'b000));
    vecs.push_back(mk(OP_SW,3'd2,0,0,0, 5,6'b010100,2'b00,2'b00,2'b00,2'b01,3'b000,0,3'b000));
    vecs.push_back(mk(OP_SW,3'd2,0,0,1, 5,6'b010100,2'b00,2'b00,2'b00,2'b01,3'b000,0,3'b000));
    // fetch stall, then R-type sub
    vecs.push_back(mk(OP_R,3'd0,1,0,0, 0,6'b000000,2'b10,2'b00,2'b10,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_R,3'd0,1,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b00,3'b000,1,3'b000));
    vecs.push_back(mk(OP_R,3'd0,1,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_R,3'd0,1,0,1, 6,6'b000000,2'b00,2'b10,2'b00,2'b00,3'b001,0,3'b001));
    vecs.push_back(mk(OP_R,3'd0,1,0,1, 7,6'b000010,2'b00,2'b00,2'b00,2'b00,3'b000,0,3'b000));
    // addi with funct7b5=1 stays add
    vecs.push_back(mk(OP_I,3'd0,1,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b00,3'b000,1,3'b000));
    vecs.push_back(mk(OP_I,3'd0,1,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_I,3'd0,1,0,1, 8,6'b000000,2'b00,2'b10,2'b01,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_I,3'd0,1,0,1, 7,6'b000010,2'b00,2'b00,2'b00,2'b00,3'b000,0,3'b000));
    // R-type xor: add without EXT_ALU, xor with it
    vecs.push_back(mk(OP_R,3'd4,0,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b00,3'b000,1,3'b000));
    vecs.push_back(mk(OP_R,3'd4,0,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_R,3'd4,0,0,1, 6,6'b000000,2'b00,2'b10,2'b00,2'b00,3'b000,0,3'b100));
    vecs.push_back(mk(OP_R,3'd4,0,0,1, 7,6'b000010,2'b00,2'b00,2'b00,2'b00,3'b000,0,3'b000));
    // ori -> or
    vecs.push_back(mk(OP_I,3'd6,0,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b00,3'b000,1,3'b000));
    vecs.push_back(mk(OP_I,3'd6,0,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b00,3'b000,0,3'b000));
    vecs.push_back(mk(OP_I,3'd6,0,0,1, 8,6'b000000,2'b00,2'b10,2'b01,2'b00,3'b011,0,3'b011));
    vecs.push_back(mk(OP_I,3'd6,0,0,1, 7,6'b000010,2'b00,2'b00,2'b00,2'b00,3'b000,0,3'b000));
    // beq taken / not taken
    vecs.push_back(mk(OP_BR,3'd0,0,1,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b10,3'b000,1,3'b000));
    vecs.push_back(mk(OP_BR,3'd0,0,1,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b10,3'b000,0,3'b000));
    vecs.push_back(mk(OP_BR,3'd0,0,1,1,10,6'b100000,2'b00,2'b10,2'b00,2'b10,3'b001,1,3'b001));
    vecs.push_back(mk(OP_BR,3'd0,0,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b10,3'b000,1,3'b000));
    vecs.push_back(mk(OP_BR,3'd0,0,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b10,3'b000,0,3'b000));
    vecs.push_back(mk(OP_BR,3'd0,0,0,1,10,6'b000000,2'b00,2'b10,2'b00,2'b10,3'b001,0,3'b001));
    // bne zero=0 then zero=1 (second instance treats both as beq)
    vecs.push_back(mk(OP_BR,3'd1,0,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b10,3'b000,1,3'b000));
    vecs.push_back(mk(OP_BR,3'd1,0,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b10,3'b000,0,3'b000));
    vecs.push_back(mk(OP_BR,3'd1,0,0,1,10,6'b100000,2'b00,2'b10,2'b00,2'b10,3'b001,0,3'b001));
    vecs.push_back(mk(OP_BR,3'd1,0,1,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b10,3'b000,1,3'b000));
    vecs.push_back(mk(OP_BR,3'd1,0,1,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b10,3'b000,0,3'b000));
    vecs.push_back(mk(OP_BR,3'd1,0,1,1,10,6'b000000,2'b00,2'b10,2'b00,2'b10,3'b001,1,3'b001));
    // jal
    vecs.push_back(mk(OP_JAL,3'd0,0,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b11,3'b000,1,3'b000));
    vecs.push_back(mk(OP_JAL,3'd0,0,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b11,3'b000,0,3'b000));
    vecs.push_back(mk(OP_JAL,3'd0,0,0,1, 9,6'b100000,2'b00,2'b01,2'b10,2'b11,3'b000,1,3'b000));
    vecs.push_back(mk(OP_JAL,3'd0,0,0,1, 7,6'b000010,2'b00,2'b00,2'b00,2'b11,3'b000,0,3'b000));
    // unsupported opcode (lui)
    vecs.push_back(mk(OP_LUI,3'd0,0,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b00,3'b000,1,3'b000));
    vecs.push_back(mk(OP_LUI,3'd0,0,0,1, 1,6'b000001,2'b00,2'b01,2'b01,2'b00,3'b000,0,3'b000));
    // sw leading into the reset-during-wait sequence
    vecs.push_back(mk(OP_SW,3'd2,0,0,1, 0,6'b101000,2'b10,2'b00,2'b10,2'b01,3'b000,1,3'b000));
    vecs.push_back(mk(OP_SW,3'd2,0,0,1, 1,6'b000000,2'b00,2'b01,2'b01,2'b01,3'b000,0,3'b000));
    vecs.push_back(mk(OP_SW,3'd2,0,0,1, 2,6'b000000,2'b00,2'b10,2'b01,2'b01,3'b000,0,3'b000));

    rst_n = 1'b0; opcode = OP_LW; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
      zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #2;
      chk($sformatf("v%0d state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("v%0d ctl", i),
          32'({pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal,
               resultsrc, alusrca, alusrcb, immsrc, alucontrol}),
          32'({vecs[i].ctl, vecs[i].rs, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].alu}));
      chk($sformatf("v%0d dut2", i), 32'({pcwrite2, alucontrol2}),
          32'({(vecs[i].st == 4'd10) ? vecs[i].pc2 : vecs[i].ctl[5], vecs[i].alu2}));
      $display("vec %0d op=%b f3=%0d rdy=%0d state=%0d", i, opcode, funct3, mem_ready, state_o);
      tick();
    end

    // reset asserted in the middle of a MEMWRITE wait
    mem_ready = 1'b0;
    #2;
    chk("mw wait1", 32'({state_o, memwrite}), 32'({4'd5, 1'b1}));
    tick();
    #2;
    chk("mw wait2", 32'({state_o, memwrite}), 32'({4'd5, 1'b1}));
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst mid-wait", 32'({state_o, memwrite, pcwrite, irwrite, regwrite, illegal}), 32'd0);
    chk("rst dut2", 32'({state_o2, memwrite2, irwrite2}), 32'd0);
    $display("reset mid-wait state=%0d memwrite=%0d", state_o, memwrite);
    tick();
    rst_n = 1'b1;
    #1;
    chk("not started", 32'({state_o, irwrite, pcwrite}), 32'd0);
    tick();
    #1;
    chk("started fetch", 32'({state_o, irwrite, pcwrite}), 32'({4'd0, 1'b1, 1'b1}));
    tick();
    #1;
    chk("after fetch", 32'(state_o), 32'd1);
    $display("reset recovery state=%0d", state_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
